// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// fetch state encoding and the NOP instruction word.
package fetch_unit_pkg;

  localparam int PC_WIDTH_DEF    = 8;
  localparam int INSTR_WIDTH_DEF = 16;

  localparam logic [15:0] INSTR_NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: async reset to RESET_PC, load of a jump target
// (priority over increment) or +1 increment with modulo-2^PC_WIDTH wrap.
module pc_counter #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic [PC_WIDTH-1:0] load_adr,
  input  logic                inc_en,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_WIDTH'(RESET_PC);
    end else if (load_en) begin
      pc_q <= load_adr;
    end else if (inc_en) begin
      pc_q <= pc_q + PC_WIDTH'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/FETCH/EXEC sequencer, instruction register
// and PC. Optional single-step input enabled by macro FETCH_SINGLE_STEP_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic                   step,
`endif
  input  logic                   jump_en,
  input  logic [PC_WIDTH-1:0]    jump_adr,
  output logic                   imem_rd_en,
  output logic [PC_WIDTH-1:0]    imem_adr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   imem_valid,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc
);

  fetch_state_e state_q, state_d;

  logic                   capture;
  logic                   pc_load;
  logic                   pc_inc;
  logic [INSTR_WIDTH-1:0] instr_p1;
  logic                   vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A stepped fetch needs no extra state: with run low, EXEC falls back to IDLE.
  always_comb begin
    state_d    = state_q;
    imem_rd_en = 1'b0;
    capture    = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end
`ifdef FETCH_SINGLE_STEP_EN
        else if (step) begin
          state_d = ST_FETCH;
        end
`endif
      end
      ST_FETCH: begin
        imem_rd_en = 1'b1;
        if (imem_valid) begin
          capture = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_load = jump_en;
        pc_inc  = !jump_en;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 1: instruction register, held between captures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p1 <= INSTR_WIDTH'(INSTR_NOP);
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= capture;
      if (capture) begin
        instr_p1 <= imem_data;
      end
    end
  end

  pc_counter #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (pc_load),
    .load_adr (jump_adr),
    .inc_en   (pc_inc),
    .pc       (pc)
  );

  assign imem_adr    = pc;
  assign instruction = instr_p1;
  assign instr_valid = vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a ROM model with programmable wait states
// and a decoder stub that jumps on words with bit 15 set.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        jump_en;
  logic [7:0]  jump_adr;
  logic        imem_rd_en;
  logic [7:0]  imem_adr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;

  logic [15:0] rom [0:255];
  int          wait_req;
  int          wcnt;
  logic        force_valid;
  logic        jump_force;

  int n_checks;
  int n_fail;

  logic [23:0] exp_q [$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
`ifdef FETCH_SINGLE_STEP_EN
    .step        (step),
`endif
    .jump_en     (jump_en),
    .jump_adr    (jump_adr),
    .imem_rd_en  (imem_rd_en),
    .imem_adr    (imem_adr),
    .imem_data   (imem_data),
    .imem_valid  (imem_valid),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data  = rom[imem_adr];
  assign imem_valid = force_valid | (imem_rd_en && (wcnt == wait_req));
  assign jump_en    = jump_force | (instr_valid & instruction[15]);
  assign jump_adr   = jump_force ? 8'hAA : instruction[7:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       wcnt <= 0;
    else if (!imem_rd_en || imem_valid) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: every EXEC cycle must match the oldest expected (address, word)
  always @(negedge clk) begin
    if (rst_n && instr_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_exec: got pc=%0h instr=%0h expected none", pc, instruction);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("exec_pc", {24'h0, pc}, {24'h0, e[23:16]});
        chk("exec_instr", {16'h0, instruction}, {16'h0, e[15:0]});
      end
    end
  end

  // FETCH cycle with a ready ROM: check request, queue expectation, move to EXEC
  task automatic fe(input logic [7:0] adr);
    chk("fetch_rd_en", {31'h0, imem_rd_en}, 32'h1);
    chk("fetch_adr", {24'h0, imem_adr}, {24'h0, adr});
    chk("fetch_no_valid", {31'h0, instr_valid}, 32'h0);
    exp_q.push_back({adr, rom[adr]});
    @(negedge clk);
    chk("exec_valid", {31'h0, instr_valid}, 32'h1);
    chk("exec_rd_en", {31'h0, imem_rd_en}, 32'h0);
  endtask

  task automatic chk_idle(input logic [7:0] p);
    chk("idle_pc", {24'h0, pc}, {24'h0, p});
    chk("idle_rd_en", {31'h0, imem_rd_en}, 32'h0);
    chk("idle_valid", {31'h0, instr_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
    rom[8'h03] = 16'h8042;
    rom[8'h45] = 16'h80FF;
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    wait_req = 0; force_valid = 1'b0; jump_force = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_pc", {24'h0, pc}, 32'h0);
    chk("rst_instr", {16'h0, instruction}, 32'h0);
    chk_idle(8'h00);

    // sequential run with a FETCH-phase jump pulse and a GOTO at pc 3
    rst_n = 1'b1; run = 1'b1;
    @(negedge clk);
    fe(8'h00); @(negedge clk);
    jump_force = 1'b1;
    fe(8'h01);
    jump_force = 1'b0;
    @(negedge clk); fe(8'h02);
    @(negedge clk); fe(8'h03);
    @(negedge clk); fe(8'h42);
    @(negedge clk); fe(8'h43);

    // three wait states
    wait_req = 3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("wait_rd_en", {31'h0, imem_rd_en}, 32'h1);
      chk("wait_adr", {24'h0, imem_adr}, 32'h44);
      chk("wait_no_valid", {31'h0, instr_valid}, 32'h0);
      @(negedge clk);
    end
    fe(8'h44);
    wait_req = 0;
    @(negedge clk); fe(8'h45);
    @(negedge clk); fe(8'hFF);

    // wrap to 0, then drop run mid-FETCH
    wait_req = 2;
    @(negedge clk);
    chk("wrap_adr", {24'h0, imem_adr}, 32'h0);
    chk("wrap_rd_en", {31'h0, imem_rd_en}, 32'h1);
    exp_q.push_back({8'h00, rom[0]});
    run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) seen = 1'b1;
    end
    chk("stop_exec_seen", {31'h0, seen}, 32'h1);
    wait_req = 0;
    @(negedge clk);
    chk_idle(8'h01);
    force_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle(8'h01);
      chk("idle_instr_hold", {16'h0, instruction}, {16'h0, rom[0]});
    end
    force_valid = 1'b0;

    // asynchronous reset in a stalled FETCH at pc 5
    rom[8'h01] = 16'h8005;
    run = 1'b1;
    @(negedge clk); fe(8'h01);
    wait_req = 5;
    @(negedge clk);
    chk("pre_rst_adr", {24'h0, imem_adr}, 32'h05);
    chk("pre_rst_rd_en", {31'h0, imem_rd_en}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", {24'h0, pc}, 32'h0);
    chk("async_rst_instr", {16'h0, instruction}, 32'h0);
    chk("async_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("async_rst_rd_en", {31'h0, imem_rd_en}, 32'h0);
    run = 1'b0;
    wait_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    force_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle(8'h00);
    end
    force_valid = 1'b0;

`ifdef FETCH_SINGLE_STEP_EN
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    fe(8'h00);
    @(negedge clk); chk_idle(8'h01);
    @(negedge clk); chk_idle(8'h01);
    run = 1'b1; step = 1'b1;
    @(negedge clk); fe(8'h01);
    @(negedge clk); fe(8'h05);
    run = 1'b0; step = 1'b0;
    @(negedge clk); chk_idle(8'h06);
    @(negedge clk); chk_idle(8'h06);
`endif

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
